// File: rtl/kbd_pkg.sv
// Shared types and constants for the KR580 PS/2 keyboard port controller.
// Covers the decoder states, AT scan codes, port offsets and queue entry layout.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] OFS_DATA = 8'd0;
  localparam logic [7:0] OFS_STAT = 8'd1;
  localparam logic [7:0] OFS_CTRL = 8'd2;
  localparam logic [7:0] OFS_MOD  = 8'd3;
  localparam logic [7:0] OFS_CNT  = 8'd4;
  localparam logic [7:0] NUM_PORTS = 8'd5;

  localparam int ENT_W    = 10;
  localparam int ENT_CODE = 0;
  localparam int ENT_REL  = 8;
  localparam int ENT_EXT  = 9;

  // Codes in the E0..EF range are passed through untouched; others carry rel in bit 7.
  function automatic logic [7:0] ev_code(input logic rel, input logic [7:0] ascii);
    if (ascii[7:4] == 4'hE) return ascii;
    return {rel, ascii[6:0]};
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous show-ahead FIFO for keyboard events.
// A pop in the same cycle frees a slot, so a push into a full FIFO is then accepted.
module kbd_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENT_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             push_ok_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  assign full_o    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_pop    = pop_i & ~empty_o & ~flush_i;
  assign push_ok_o = push_i & ~flush_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok_o && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push_ok_o && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/kbd_port_fifo.sv
// Port-mapped PS/2 keyboard controller: decodes E0/F0 prefixes, tracks modifiers
// and queues key events for the CPU behind five consecutive I/O ports.
module kbd_port_fifo
  import kbd_pkg::*;
#(
  parameter logic [7:0] BASE_PORT    = 8'hF8,
  parameter int         DEPTH        = 8,
  parameter bit         DROP_RELEASE = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  input  logic [7:0] kb_ascii,
  input  logic [7:0] pin_pa,
  input  logic [7:0] pin_po,
  input  logic       pin_pw,
  input  logic       pin_pr,
  output logic       port_hit,
  output logic [7:0] port_rdata
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  dec_state_e       state_q, state_d;
  logic [4:0]       mod_q, mod_d;
  logic [7:0]       evcnt_q, evcnt_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;

  logic             evt_vld, evt_ext, evt_rel;
  logic [ENT_W-1:0] evt_entry, head;
  logic [7:0]       ofs;
  logic             ctrl_wr, flush, pop, push_req, push_ok;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [4:0]       cnt5;
  logic             unused_po;

  assign ofs       = pin_pa - BASE_PORT;
  assign port_hit  = (ofs < NUM_PORTS);
  assign ctrl_wr   = pin_pw & port_hit & (ofs == OFS_CTRL);
  assign flush     = ctrl_wr & pin_po[0];
  assign pop       = pin_pr & port_hit & (ofs == OFS_DATA);
  assign push_req  = evt_vld & ~(evt_rel & drop_q);
  assign evt_entry = {evt_ext, evt_rel, ev_code(evt_rel, kb_ascii)};
  assign cnt5      = 5'(fifo_cnt);
  assign unused_po = ^pin_po[7:3];

  // Prefix decoder: E0/F0 only act as prefixes from IDLE/EXT.
  always_comb begin
    state_d = state_q;
    evt_vld = 1'b0;
    evt_ext = 1'b0;
    evt_rel = 1'b0;
    if (ps2_data_en) begin
      case (state_q)
        IDLE: begin
          if (ps2_data == SC_EXT)      state_d = EXT;
          else if (ps2_data == SC_BRK) state_d = BRK;
          else                         evt_vld = 1'b1;
        end
        EXT: begin
          if (ps2_data == SC_BRK) state_d = EXT_BRK;
          else begin
            evt_vld = 1'b1;
            evt_ext = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          evt_vld = 1'b1;
          evt_rel = 1'b1;
          state_d = IDLE;
        end
        default: begin
          evt_vld = 1'b1;
          evt_ext = 1'b1;
          evt_rel = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mod_d = mod_q;
    if (evt_vld) begin
      if (!evt_ext && ps2_data == SC_LSHIFT) mod_d[0] = ~evt_rel;
      if (!evt_ext && ps2_data == SC_RSHIFT) mod_d[1] = ~evt_rel;
      if (ps2_data == SC_CTRL)               mod_d[2] = ~evt_rel;
      if (ps2_data == SC_ALT)                mod_d[3] = ~evt_rel;
      if (!evt_ext && !evt_rel && ps2_data == SC_CAPS) mod_d[4] = ~mod_q[4];
    end
  end

  // Overflow set beats a clear written in the same cycle.
  always_comb begin
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    evcnt_d = evcnt_q;
    if (ctrl_wr) begin
      drop_d = pin_po[2];
      if (pin_po[1]) ovf_d = 1'b0;
    end
    if (push_req && !push_ok && !flush) ovf_d = 1'b1;
    if (push_ok) evcnt_d = evcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mod_q   <= '0;
      evcnt_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= DROP_RELEASE;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      evcnt_q <= evcnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  kbd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .push_i    (push_req),
    .pop_i     (pop),
    .flush_i   (flush),
    .data_i    (evt_entry),
    .head_o    (head),
    .push_ok_o (push_ok),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_cnt)
  );

  always_comb begin
    port_rdata = 8'hFF;
    if (port_hit) begin
      case (ofs)
        OFS_DATA: port_rdata = fifo_empty ? 8'h00 : head[ENT_CODE +: 8];
        OFS_STAT: port_rdata = {ovf_q, head[ENT_EXT] & ~fifo_empty,
                                head[ENT_REL] & ~fifo_empty, cnt5};
        OFS_CTRL: port_rdata = {5'b0, drop_q, 2'b0};
        OFS_MOD:  port_rdata = {3'b0, mod_q};
        default:  port_rdata = evcnt_q;
      endcase
    end
  end

endmodule
